text_console: RTL and testbench

TEXT_CONSOLE -- requirements
Module: text_console

---
 rtl/text_console_pkg.sv | 29 ++
 rtl/text_console_ram.sv | 32 +++
 rtl/text_console.sv | 188 ++++++++++++++++++
 tb/tb_text_console.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/text_console_pkg.sv
// Shared constants and types for the text console: default geometry,
// control codes, bus widths and the write-side FSM encoding.
package text_console_pkg;

  localparam int unsigned COLS = 40;
  localparam int unsigned ROWS = 30;

  localparam int unsigned PW = 10;  // pixel / cell coordinate width
  localparam int unsigned AW = 11;  // text RAM address width (2048 cells)
  localparam int unsigned DW = 8;   // character width

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } state_t;

  // Printable ASCII range that gets stored in the text RAM.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_ram.sv
// Simple dual-port text RAM, one write port and one registered read port.
// Ports: px_clk/rstn, wr_en/wr_addr/wr_data (write), rd_addr/rd_data (read).
// A same-cycle read of the address being written returns the old data.
module text_ram
  import text_console_pkg::*;
#(
  parameter int unsigned ADDR_W = AW,
  parameter int unsigned DATA_W = DW
) (
  input  logic              px_clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage array is never reset; the console clears it after reset.
  always_ff @(posedge px_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is reset, so char_code starts at zero.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/text_console.sv
// Character-cell text console: accepts an ASCII stream, keeps cursor,
// scroll offset and blink state, and looks up the character under the
// current pixel for the font stage.
// Ports: px_clk/rstn; wr_valid/wr_data/wr_ready (character input);
// px_x/px_y/frame_tick (from sync stage); char_code/font_x/font_y/cursor_on.
module text_console
  import text_console_pkg::*;
#(
  parameter int unsigned COLS = text_console_pkg::COLS,
  parameter int unsigned ROWS = text_console_pkg::ROWS,
  parameter int unsigned ZOOM = 1
) (
  input  logic          px_clk,
  input  logic          rstn,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  input  logic [PW-1:0] px_x,
  input  logic [PW-1:0] px_y,
  input  logic          frame_tick,
  output logic [7:0]    char_code,
  output logic [PW-1:0] font_x,
  output logic [PW-1:0] font_y,
  output logic          cursor_on
);

  localparam int unsigned SH    = 3 + ZOOM;
  localparam int unsigned CELLS = COLS * ROWS;

  // Linear RAM address of a physical row / column.
  function automatic logic [AW-1:0] cell_addr(input logic [PW-1:0] row,
                                              input logic [AW-1:0] col);
    return AW'(row) * AW'(COLS) + col;
  endfunction

  // Physical RAM row of screen row r given the scroll offset.
  function automatic logic [PW-1:0] row_phys(input logic [PW-1:0] r,
                                             input logic [PW-1:0] top);
    logic [PW:0] s;
    s = {1'b0, r} + {1'b0, top};
    if (s >= (PW+1)'(ROWS)) s = s - (PW+1)'(ROWS);
    return s[PW-1:0];
  endfunction

  state_t        state, state_d;
  logic [PW-1:0] cur_col, cur_row, top_row;
  logic [AW-1:0] clr_cnt;
  logic [4:0]    blink_cnt;
  logic          wr_ready_d;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [7:0]    ram_rdata;

  logic          accept, printable, advance, scroll;

  assign accept    = wr_valid && wr_ready;
  assign printable = is_printable(wr_data);
  assign advance   = accept && ((printable && (cur_col == PW'(COLS-1))) || (wr_data == LF));
  assign scroll    = advance && (cur_row == PW'(ROWS-1));

  // State register
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) state <= CLR_ALL;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept && (wr_data == FF)) state_d = CLR_ALL;
        else if (scroll)               state_d = CLR_ROW;
      end
      CLR_ROW: if (clr_cnt == AW'(COLS-1))  state_d = IDLE;
      CLR_ALL: if (clr_cnt == AW'(CELLS-1)) state_d = IDLE;
      default: state_d = CLR_ALL;
    endcase
  end

  // FSM outputs: RAM write port and next wr_ready
  always_comb begin
    ram_we     = 1'b0;
    ram_waddr  = '0;
    ram_wdata  = SPACE;
    wr_ready_d = (state_d == IDLE);
    unique case (state)
      IDLE: begin
        if (accept && printable) begin
          ram_we    = 1'b1;
          ram_waddr = cell_addr(row_phys(cur_row, top_row), AW'(cur_col));
          ram_wdata = wr_data;
        end else if (accept && (wr_data == BS) && (cur_col != '0)) begin
          ram_we    = 1'b1;
          ram_waddr = cell_addr(row_phys(cur_row, top_row), AW'(cur_col - PW'(1)));
        end
      end
      // top_row already points past the row being blanked
      CLR_ROW: begin
        ram_we    = 1'b1;
        ram_waddr = cell_addr(row_phys(PW'(ROWS-1), top_row), clr_cnt);
      end
      CLR_ALL: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt;
      end
      default: ram_we = 1'b0;
    endcase
  end

  // Handshake, clear counter and cursor / scroll registers
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ready <= 1'b0;
      clr_cnt  <= '0;
      cur_col  <= '0;
      cur_row  <= '0;
      top_row  <= '0;
    end else begin
      wr_ready <= wr_ready_d;
      clr_cnt  <= ((state != IDLE) && (state_d == state)) ? clr_cnt + AW'(1) : '0;
      if (accept) begin
        if (printable) begin
          cur_col <= (cur_col == PW'(COLS-1)) ? '0 : cur_col + PW'(1);
        end else if (wr_data == CR) begin
          cur_col <= '0;
        end else if ((wr_data == BS) && (cur_col != '0)) begin
          cur_col <= cur_col - PW'(1);
        end else if (wr_data == FF) begin
          cur_col <= '0;
          cur_row <= '0;
          top_row <= '0;
        end
      end
      if (advance) begin
        if (!scroll)                           cur_row <= cur_row + PW'(1);
        else if (top_row == PW'(ROWS-1))       top_row <= '0;
        else                                   top_row <= top_row + PW'(1);
      end
    end
  end

  // Cursor blink phase
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn)           blink_cnt <= '0;
    else if (frame_tick) blink_cnt <= blink_cnt + 5'd1;
  end

  // Read path: pixel -> cell -> physical RAM address
  logic [PW-1:0] rd_col, rd_row;
  logic          rd_oob, oob_q;

  assign rd_col    = px_x >> SH;
  assign rd_row    = px_y >> SH;
  assign rd_oob    = (rd_col >= PW'(COLS)) || (rd_row >= PW'(ROWS));
  assign ram_raddr = cell_addr(row_phys(rd_row, top_row), AW'(rd_col));

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      oob_q     <= 1'b0;
      font_x    <= '0;
      font_y    <= '0;
      cursor_on <= 1'b0;
    end else begin
      oob_q     <= rd_oob;
      font_x    <= px_x >> ZOOM;
      font_y    <= px_y >> ZOOM;
      cursor_on <= (rd_row == cur_row) && (rd_col == cur_col) && blink_cnt[4];
    end
  end

  // Both mux inputs are flops aligned with font_x/font_y
  assign char_code = oob_q ? SPACE : ram_rdata;

  text_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
    .px_clk  (px_clk),
    .rstn    (rstn),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

endmodule

// File: tb/tb_text_console.sv
// Directed self-checking bench for text_console (default 40x30, ZOOM=1,
// so each cell is 16x16 pixels).
module tb_text_console;

  logic       px_clk = 1'b0;
  logic       rstn;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [9:0] px_x, px_y;
  logic       frame_tick;
  logic [7:0] char_code;
  logic [9:0] font_x, font_y;
  logic       cursor_on;

  int n_checks = 0;
  int n_errors = 0;

  text_console dut (
    .px_clk     (px_clk),
    .rstn       (rstn),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .px_x       (px_x),
    .px_y       (px_y),
    .frame_tick (frame_tick),
    .char_code  (char_code),
    .font_x     (font_x),
    .font_y     (font_y),
    .cursor_on  (cursor_on)
  );

  always #5 px_clk = ~px_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one byte and hold it for exactly one accepting edge.
  task automatic put_char(input logic [7:0] b);
    int n = 0;
    @(negedge px_clk);
    while (!wr_ready && n < 5000) begin
      @(negedge px_clk);
      n++;
    end
    if (!wr_ready) check("put_char_timeout", 32'd0, 32'd1);
    wr_valid = 1'b1;
    wr_data  = b;
    @(posedge px_clk);
    #1;
    wr_valid = 1'b0;
  endtask

  // Count clock periods with wr_ready low, starting just after an edge.
  task automatic busy_cycles(output int n);
    n = 0;
    while (!wr_ready && n < 5000) begin
      @(posedge px_clk);
      #1;
      n++;
    end
  endtask

  task automatic read_px(input int x, input int y, output logic [7:0] c, output logic cur);
    @(negedge px_clk);
    px_x = 10'(x);
    px_y = 10'(y);
    @(posedge px_clk);
    #1;
    c   = char_code;
    cur = cursor_on;
  endtask

  task automatic frame_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge px_clk);
      frame_tick = 1'b1;
      @(negedge px_clk);
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         bad;
    logic [7:0] c;
    logic       cur;

    rstn = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
    px_x = 10'd100; px_y = 10'd40; frame_tick = 1'b0;
    repeat (3) @(posedge px_clk);
    #1;
    check("rst_char_code", char_code, 8'h00);
    check("rst_font_x",    font_x,    0);
    check("rst_font_y",    font_y,    0);
    check("rst_cursor_on", cursor_on, 0);
    check("rst_wr_ready",  wr_ready,  0);

    // Scenario 1: power-up clear
    @(negedge px_clk);
    rstn = 1'b1;
    busy_cycles(n);
    check("s1_clear_cycles", n, 1200);
    bad = 0;
    for (int r = 0; r < 30; r++)
      for (int col = 0; col < 40; col++) begin
        read_px(col * 16, r * 16, c, cur);
        if (c != 8'h20) bad++;
      end
    check("s1_blank_cells", bad, 0);

    // Scenario 2: 'A','B'
    put_char(8'h41);
    put_char(8'h42);
    read_px(16, 0, c, cur);
    check("s2_cell1", c, 8'h42);
    check("s2_font_x", font_x, 8);
    read_px(0, 0, c, cur);
    check("s2_cell0", c, 8'h41);
    check("s2_cur_col", dut.cur_col, 2);
    check("s2_cursor_blink_off", cur, 0);

    // Form feed clears the whole screen again
    put_char(8'h0C);
    busy_cycles(n);
    check("ff_clear_cycles", n, 1200);
    read_px(16, 0, c, cur);
    check("ff_cell1_blank", c, 8'h20);

    // Scenario 3: a full line wraps the cursor
    for (int i = 0; i < 40; i++) put_char(8'h78);
    check("s3_cur_col", dut.cur_col, 0);
    check("s3_cur_row", dut.cur_row, 1);
    read_px(0, 16, c, cur);
    check("s3_row1_blank", c, 8'h20);
    read_px(624, 0, c, cur);
    check("s3_last_col", c, 8'h78);

    // Scenario 4: scroll
    put_char(8'h0C);
    busy_cycles(n);
    for (int i = 0; i < 29; i++) put_char(8'h0A);
    check("s4_cur_row_29", dut.cur_row, 29);
    put_char(8'h51);
    put_char(8'h0A);
    busy_cycles(n);
    check("s4_scroll_cycles", n, 40);
    read_px(0, 448, c, cur);
    check("s4_q_on_row28", c, 8'h51);
    read_px(0, 464, c, cur);
    check("s4_row29_blank", c, 8'h20);
    read_px(0, 480, c, cur);
    check("s4_row_oob", c, 8'h20);
    check("s4_cur_row_kept", dut.cur_row, 29);
    check("s4_cur_col", dut.cur_col, 1);

    // Scenario 5: backspace and ignored control byte
    put_char(8'h0C);
    busy_cycles(n);
    put_char(8'h41);
    put_char(8'h08);
    read_px(0, 0, c, cur);
    check("s5_bs_blank", c, 8'h20);
    check("s5_cur_col", dut.cur_col, 0);
    put_char(8'h08);
    check("s5_bs_at_col0", dut.cur_col, 0);
    put_char(8'h07);
    check("s5_bel_col", dut.cur_col, 0);
    check("s5_bel_row", dut.cur_row, 0);
    check("s5_bel_ready", wr_ready, 1);
    read_px(0, 0, c, cur);
    check("s5_bel_cell", c, 8'h20);

    // Scenario 6: cursor blink
    read_px(0, 0, c, cur);
    check("s6_cursor_before", cur, 0);
    frame_ticks(16);
    read_px(0, 0, c, cur);
    check("s6_cursor_on", cur, 1);
    read_px(16, 0, c, cur);
    check("s6_cursor_other_cell", cur, 0);
    read_px(700, 0, c, cur);
    check("s6_col_oob", c, 8'h20);
    frame_ticks(16);
    read_px(0, 0, c, cur);
    check("s6_cursor_wrapped", cur, 0);

    // Reset in the middle of a clear restarts a full pass
    put_char(8'h43);
    put_char(8'h0C);
    repeat (100) @(posedge px_clk);
    @(negedge px_clk);
    rstn = 1'b0;
    @(negedge px_clk);
    check("rst2_wr_ready", wr_ready, 0);
    rstn = 1'b1;
    busy_cycles(n);
    check("rst2_clear_cycles", n, 1200);
    read_px(0, 0, c, cur);
    check("rst2_cell0_blank", c, 8'h20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
